// File: rtl/trap_pkg.sv
// Shared types and constants for the trap request arbiter.
// States, default widths and named exception causes.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    IN_TRAP,
    COOLDOWN
  } arb_state_t;

  localparam int DEF_CAUSE_W = 6;

  localparam logic [DEF_CAUSE_W-1:0] ILLEGAL_INSTR = 6'd2;
  localparam logic [DEF_CAUSE_W-1:0] LOAD_FAULT    = 6'd5;
  localparam logic [DEF_CAUSE_W-1:0] ECALL_M       = 6'd11;

endpackage

// File: rtl/trap_priority_encoder.sv
// Lowest-index-wins encoder over the eligible interrupt vector.
// Purely combinational.
module trap_priority_encoder #(
  parameter  int NUM_IRQ = 4,
  localparam int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] eligible_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   index_o
);

  // scan high to low so the lowest set bit is written last
  always_comb begin
    any_o   = |eligible_i;
    index_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible_i[i]) index_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/trap_request_arbiter.sv
// Picks one trap (exception over interrupt), latches it and
// hands it to the handler; single-issue until mret.
module trap_request_arbiter
  import trap_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int CAUSE_W = DEF_CAUSE_W,
  parameter int XLEN    = 64
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               exc_valid_i,
  input  logic [CAUSE_W-1:0] exc_cause_i,
  input  logic [XLEN-1:0]    exc_tval_i,
  output logic               exc_ready_o,
  input  logic [NUM_IRQ-1:0] irq_pending_i,
  input  logic [NUM_IRQ-1:0] irq_enable_i,
  input  logic               global_ie_i,
  output logic               trap_valid_o,
  input  logic               trap_ready_i,
  output logic               trap_is_irq_o,
  output logic [CAUSE_W-1:0] trap_cause_o,
  output logic [XLEN-1:0]    trap_tval_o,
  output logic [NUM_IRQ-1:0] irq_claim_o,
  input  logic               mret_i,
  output logic               busy_o,
  output logic               double_fault_o
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  if (NUM_IRQ < 1 || NUM_IRQ > 16 ||
      NUM_IRQ > (1 << CAUSE_W)) begin : g_bad_cfg
    $error("trap_request_arbiter: bad NUM_IRQ/CAUSE_W");
  end

  arb_state_t state_q, state_d;

  logic [NUM_IRQ-1:0] eligible;
  logic               irq_any;
  logic [IDX_W-1:0]   irq_idx;

  logic               accept_exc;
  logic               accept_irq;
  logic               xfer;
  logic               set_df;

  logic               is_irq_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [XLEN-1:0]    tval_q;
  logic [NUM_IRQ-1:0] claim_q;
  logic               df_q;

  assign eligible = irq_pending_i & irq_enable_i
                  & {NUM_IRQ{global_ie_i}};

  trap_priority_encoder #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .eligible_i (eligible),
    .any_o      (irq_any),
    .index_o    (irq_idx)
  );

  // state register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next state and per-cycle strobes
  always_comb begin
    state_d    = state_q;
    accept_exc = 1'b0;
    accept_irq = 1'b0;
    xfer       = 1'b0;
    set_df     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exc_valid_i) begin
          accept_exc = 1'b1;
          state_d    = REQUEST;
        end else if (irq_any) begin
          accept_irq = 1'b1;
          state_d    = REQUEST;
        end
      end
      REQUEST: begin
        if (trap_ready_i) begin
          xfer    = 1'b1;
          state_d = IN_TRAP;
        end
      end
      IN_TRAP: begin
        if (mret_i)           state_d = COOLDOWN;
        else if (exc_valid_i) set_df  = 1'b1;
      end
      COOLDOWN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // trap record, claim pulse and sticky double fault
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      is_irq_q <= 1'b0;
      cause_q  <= '0;
      tval_q   <= '0;
      claim_q  <= '0;
      df_q     <= 1'b0;
    end else begin
      if (accept_exc) begin
        is_irq_q <= 1'b0;
        cause_q  <= exc_cause_i;
        tval_q   <= exc_tval_i;
      end else if (accept_irq) begin
        is_irq_q <= 1'b1;
        cause_q  <= CAUSE_W'(irq_idx);
        tval_q   <= '0;
      end
      if (xfer && is_irq_q)
        claim_q <= NUM_IRQ'(1) << cause_q[IDX_W-1:0];
      else
        claim_q <= '0;
      df_q <= df_q | set_df;
    end
  end

  assign exc_ready_o    = (state_q == IDLE);
  assign trap_valid_o   = (state_q == REQUEST);
  assign busy_o         = (state_q != IDLE);
  assign trap_is_irq_o  = is_irq_q;
  assign trap_cause_o   = cause_q;
  assign trap_tval_o    = tval_q;
  assign irq_claim_o    = claim_q;
  assign double_fault_o = df_q;

endmodule

// File: tb/tb_trap_request_arbiter.sv
// Randomised and directed bench for trap_request_arbiter
// against a behavioural trap-lifecycle model.
module tb_trap_request_arbiter;
  import trap_pkg::*;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        exc_valid_i;
  logic [5:0]  exc_cause_i;
  logic [63:0] exc_tval_i;
  logic        exc_ready_o;
  logic [3:0]  irq_pending_i;
  logic [3:0]  irq_enable_i;
  logic        global_ie_i;
  logic        trap_valid_o;
  logic        trap_ready_i;
  logic        trap_is_irq_o;
  logic [5:0]  trap_cause_o;
  logic [63:0] trap_tval_o;
  logic [3:0]  irq_claim_o;
  logic        mret_i;
  logic        busy_o;
  logic        double_fault_o;

  trap_request_arbiter #(
    .NUM_IRQ (4),
    .CAUSE_W (6),
    .XLEN    (64)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .exc_valid_i    (exc_valid_i),
    .exc_cause_i    (exc_cause_i),
    .exc_tval_i     (exc_tval_i),
    .exc_ready_o    (exc_ready_o),
    .irq_pending_i  (irq_pending_i),
    .irq_enable_i   (irq_enable_i),
    .global_ie_i    (global_ie_i),
    .trap_valid_o   (trap_valid_o),
    .trap_ready_i   (trap_ready_i),
    .trap_is_irq_o  (trap_is_irq_o),
    .trap_cause_o   (trap_cause_o),
    .trap_tval_o    (trap_tval_o),
    .irq_claim_o    (irq_claim_o),
    .mret_i         (mret_i),
    .busy_o         (busy_o),
    .double_fault_o (double_fault_o)
  );

  always #5 clock_i = ~clock_i;

  int n_vec = 0;
  int n_bad = 0;

  // trap lifecycle: waiting for handler, in handler, post-mret gap
  bit          m_pres, m_hand, m_cool;
  bit          m_irq, m_df;
  logic [5:0]  m_cause;
  logic [63:0] m_tval;
  logic [3:0]  m_claim;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] lowest(input logic [3:0] v);
    logic [3:0] t;
    t = v & (~v + 4'd1);
    return 6'($clog2(t));
  endfunction

  task automatic model_clear();
    m_pres  = 0; m_hand = 0; m_cool = 0;
    m_irq   = 0; m_df   = 0;
    m_cause = '0; m_tval = '0; m_claim = '0;
  endtask

  task automatic model_step();
    logic [3:0] elig;
    logic [3:0] nclaim;
    elig   = irq_pending_i & irq_enable_i & {4{global_ie_i}};
    nclaim = '0;
    if (m_pres) begin
      if (trap_ready_i) begin
        m_pres = 0;
        m_hand = 1;
        if (m_irq) nclaim = 4'b0001 << m_cause;
      end
    end else if (m_hand) begin
      if (mret_i) begin
        m_hand = 0;
        m_cool = 1;
      end else if (exc_valid_i) begin
        m_df = 1;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (exc_valid_i) begin
      m_pres  = 1;
      m_irq   = 0;
      m_cause = exc_cause_i;
      m_tval  = exc_tval_i;
    end else if (elig != 0) begin
      m_pres  = 1;
      m_irq   = 1;
      m_cause = lowest(elig);
      m_tval  = '0;
    end
    m_claim = nclaim;
  endtask

  task automatic check_outputs();
    bit idle;
    idle = !(m_pres || m_hand || m_cool);
    check("exc_ready", exc_ready_o, idle);
    check("trap_valid", trap_valid_o, m_pres);
    check("busy", busy_o, !idle);
    check("is_irq", trap_is_irq_o, m_irq);
    check("cause", trap_cause_o, m_cause);
    check("tval", trap_tval_o, m_tval);
    check("claim", irq_claim_o, m_claim);
    check("double_fault", double_fault_o, m_df);
  endtask

  task automatic clear_inputs();
    exc_valid_i   = 0;
    exc_cause_i   = '0;
    exc_tval_i    = '0;
    irq_pending_i = '0;
    irq_enable_i  = '0;
    global_ie_i   = 0;
    trap_ready_i  = 0;
    mret_i        = 0;
  endtask

  task automatic tick();
    @(posedge clock_i);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_i = 1;
    model_clear();
    #1;
    check_outputs();
    @(negedge clock_i);
    reset_i = 0;
  endtask

  initial begin
    clear_inputs();
    reset_i = 1;
    model_clear();
    #2;
    check_outputs();
    @(negedge clock_i);
    reset_i = 0;

    // exception beats interrupt
    do_reset();
    exc_valid_i   = 1;
    exc_cause_i   = ILLEGAL_INSTR;
    exc_tval_i    = 64'hDEAD;
    irq_pending_i = 4'b0010;
    irq_enable_i  = 4'b1111;
    global_ie_i   = 1;
    tick();
    check("exc_win_valid", trap_valid_o, 1);
    check("exc_win_irq", trap_is_irq_o, 0);
    check("exc_win_cause", trap_cause_o, 2);
    check("exc_win_tval", trap_tval_o, 64'hDEAD);
    exc_valid_i   = 0;
    irq_pending_i = '0;
    trap_ready_i  = 1;
    tick();
    check("exc_win_claim", irq_claim_o, 0);
    trap_ready_i = 0;
    tick();

    // interrupt priority, hold while not ready, claim pulse
    do_reset();
    irq_pending_i = 4'b1100;
    irq_enable_i  = 4'b1111;
    global_ie_i   = 1;
    tick();
    check("prio_cause", trap_cause_o, 2);
    check("prio_irq", trap_is_irq_o, 1);
    check("prio_tval", trap_tval_o, 0);
    irq_pending_i = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", trap_valid_o, 1);
      check("hold_cause", trap_cause_o, 2);
    end
    trap_ready_i = 1;
    tick();
    check("xfer_busy", busy_o, 1);
    check("xfer_valid", trap_valid_o, 0);
    check("claim_pulse", irq_claim_o, 4'b0100);
    trap_ready_i = 0;
    tick();
    check("claim_end", irq_claim_o, 0);

    // reset while a trap is presented
    do_reset();
    exc_valid_i = 1;
    exc_cause_i = LOAD_FAULT;
    tick();
    exc_valid_i = 0;
    check("pre_rst_valid", trap_valid_o, 1);
    #2;
    reset_i = 1;
    model_clear();
    #1;
    check("arst_valid", trap_valid_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_ready", exc_ready_o, 1);
    @(negedge clock_i);
    reset_i = 0;

    // masking by global enable, then by line enable
    do_reset();
    irq_pending_i = 4'b0001;
    irq_enable_i  = 4'b1111;
    global_ie_i   = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        global_ie_i  = 1;
        irq_enable_i = 4'b1110;
      end
      tick();
      check("mask_valid", trap_valid_o, 0);
      check("mask_busy", busy_o, 0);
    end

    // double fault, sticky across mret
    do_reset();
    exc_valid_i = 1;
    exc_cause_i = ECALL_M;
    tick();
    exc_valid_i  = 0;
    trap_ready_i = 1;
    tick();
    trap_ready_i = 0;
    exc_valid_i  = 1;
    exc_cause_i  = LOAD_FAULT;
    tick();
    check("df_set", double_fault_o, 1);
    exc_valid_i = 0;
    mret_i      = 1;
    tick();
    mret_i = 0;
    tick();
    tick();
    check("df_sticky", double_fault_o, 1);

    // mret together with exception: no fault, ready 2 cycles later
    do_reset();
    exc_valid_i = 1;
    exc_cause_i = ECALL_M;
    tick();
    exc_valid_i  = 0;
    trap_ready_i = 1;
    tick();
    trap_ready_i = 0;
    exc_valid_i  = 1;
    mret_i       = 1;
    tick();
    check("mret_cd_ready", exc_ready_o, 0);
    check("mret_no_df", double_fault_o, 0);
    mret_i = 0;
    tick();
    check("mret_idle_ready", exc_ready_o, 1);
    check("mret_idle_df", double_fault_o, 0);
    exc_valid_i = 0;
    tick();

    // randomised traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      exc_valid_i   = ($urandom_range(0, 9) < 2);
      exc_cause_i   = 6'($urandom);
      exc_tval_i    = {$urandom, $urandom};
      irq_pending_i = 4'($urandom);
      irq_enable_i  = 4'($urandom);
      global_ie_i   = ($urandom_range(0, 9) < 7);
      trap_ready_i  = $urandom_range(0, 1) == 1;
      mret_i        = ($urandom_range(0, 9) < 3);
      if (i == 1500) do_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/trap_request_arbiter.md
Name: trap_request_arbiter

Overview:
- Collects synchronous exceptions from the commit stage and level-sensitive interrupt lines.
- Selects one trap by fixed priority, latches its cause and tval, and presents it to the exception-handler FSM through a valid/ready handshake.
- Blocks further traps until the handler signals mret, which makes trap entry single-issue and non-nested.
- Sits between the pipeline/interrupt sources and the exception-handler FSM.

Parameters:
- NUM_IRQ, 4, number of interrupt lines (1..16)
- CAUSE_W, 6, width of the exception cause code
- XLEN, 64, width of trap value (tval)

Ports:
- clock_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  asynchronous, active-high reset
- exc_valid_i  in  1  commit stage presents an exception
- exc_cause_i  in  CAUSE_W  exception cause code
- exc_tval_i  in  XLEN  exception trap value
- exc_ready_o  out  1  arbiter accepts the exception this cycle
- irq_pending_i  in  NUM_IRQ  level interrupt lines
- irq_enable_i  in  NUM_IRQ  per-line enable mask
- global_ie_i  in  1  global interrupt enable
- trap_valid_o  out  1  trap presented to handler
- trap_ready_i  in  1  handler accepts trap (handler idle)
- trap_is_irq_o  out  1  latched trap is an interrupt
- trap_cause_o  out  CAUSE_W  latched cause; for an interrupt, the zero-extended line index
- trap_tval_o  out  XLEN  latched tval; 0 for interrupts
- irq_claim_o  out  NUM_IRQ  one-cycle one-hot pulse on the cycle after an interrupt trap is accepted
- mret_i  in  1  handler has executed mret
- busy_o  out  1  state != IDLE
- double_fault_o  out  1  sticky: exception arrived while in trap

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All outputs are 0 except exc_ready_o=1. Latched cause/tval=0. double_fault_o cleared.
- States, from arb_state_t: IDLE, REQUEST, IN_TRAP, COOLDOWN.
- Eligible interrupts: eligible = irq_pending_i & irq_enable_i & {NUM_IRQ{global_ie_i}}.
- Priority: an exception beats any interrupt. Among interrupts, the lowest index wins.
- IDLE:
  - exc_ready_o=1.
  - If exc_valid_i: latch exc_cause_i/exc_tval_i, set is_irq=0, go to REQUEST. The exception handshake completes this cycle.
  - Else if eligible != 0: latch the winning index, tval=0, is_irq=1, go to REQUEST.
  - Else stay in IDLE.
  - Latch-to-valid latency is one cycle: trap_valid_o rises on the edge that enters REQUEST.
- REQUEST:
  - trap_valid_o=1. trap_cause_o, trap_is_irq_o and trap_tval_o stay stable until transfer.
  - trap_valid_o is never withdrawn before transfer.
  - On trap_valid_o && trap_ready_i: go to IN_TRAP. If is_irq, pulse irq_claim_o[index] for exactly one cycle; it is registered and appears the cycle after transfer.
  - An interrupt line deasserting during REQUEST does not cancel the trap.
- IN_TRAP:
  - trap_valid_o=0 and exc_ready_o=0. Interrupts are ignored.
  - On mret_i: go to COOLDOWN.
  - exc_valid_i without mret_i: set double_fault_o=1 (sticky until reset). State is unchanged.
  - mret_i and exc_valid_i in the same cycle: mret wins, no double fault is flagged, and the exception stays held by the requester.
- COOLDOWN:
  - One cycle, no acceptance, then IDLE.
  - This guarantees at least one cycle between mret and the next trap entry.
- Output hold: trap_cause_o, trap_is_irq_o and trap_tval_o hold their last latched value outside REQUEST.
- Widths: the interrupt index is zero-extended to CAUSE_W. An elaboration check enforces NUM_IRQ <= 2**CAUSE_W.
- mret_i outside IN_TRAP is ignored.

Decomposition:
- Package trap_pkg holds:
  - arb_state_t (enum of the four states)
  - CAUSE_W default constant
  - named exception cause constants (ILLEGAL_INSTR=2, ECALL_M=11, LOAD_FAULT=5)
- Sub-module trap_priority_encoder: combinational, parameter NUM_IRQ. Inputs: eligible vector. Outputs: any_o and index_o (lowest set bit).

Test Plan:
- Reset mid-REQUEST: assert reset_i while trap_valid_o=1 -> trap_valid_o=0, busy_o=0, exc_ready_o=1 in the same cycle (asynchronous).
- Exception beats interrupt:
  - Stimulus: in IDLE, exc_valid_i=1, cause=2, tval=0xDEAD, and irq_pending_i=4'b0010 with all enables set.
  - Response: the next cycle trap_valid_o=1, trap_is_irq_o=0, trap_cause_o=2, trap_tval_o=0xDEAD; irq_claim_o stays 0.
- Interrupt priority:
  - Stimulus: irq_pending_i=4'b1100, irq_enable_i=4'b1111, global_ie_i=1.
  - Response: trap_cause_o=2, trap_is_irq_o=1. After trap_ready_i=1, irq_claim_o=4'b0100 for one cycle.
- Masking: irq_pending_i=4'b0001 with global_ie_i=0 or irq_enable_i[0]=0 -> state stays IDLE and trap_valid_o=0 for 20 cycles.
- Handshake hold: keep trap_ready_i=0 for 5 cycles -> trap_valid_o stays high with stable cause/tval. On trap_ready_i=1, the next cycle shows busy_o=1 and trap_valid_o=0.
- Trap exit and double fault:
  - exc_valid_i in IN_TRAP -> double_fault_o=1 and stays set after a later mret.
  - mret_i together with exc_valid_i -> no double fault; exc_ready_o rises exactly 2 cycles after mret_i (COOLDOWN, then IDLE).
